// File: rtl/ysyx_22050518_mem_arbiter.sv
// Two-master memory arbiter: icache (m0) and dcache (m1) share one bus port.
// Read and write paths hold their grant for a whole BEATS-beat line.
module ysyx_22050518_mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32,
  parameter int BEATS  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_ravalid,
  input  logic [ADDR_W-1:0] m0_raaddr,
  output logic              m0_raready,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m0_rready,
  input  logic              m0_wavalid,
  input  logic [ADDR_W-1:0] m0_waaddr,
  output logic              m0_waready,
  input  logic              m0_wvalid,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_wready,
  output logic              m0_bvalid,
  output logic [1:0]        m0_bresp,
  input  logic              m0_bready,
  input  logic              m1_ravalid,
  input  logic [ADDR_W-1:0] m1_raaddr,
  output logic              m1_raready,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  input  logic              m1_rready,
  input  logic              m1_wavalid,
  input  logic [ADDR_W-1:0] m1_waaddr,
  output logic              m1_waready,
  input  logic              m1_wvalid,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_wready,
  output logic              m1_bvalid,
  output logic [1:0]        m1_bresp,
  input  logic              m1_bready,
  output logic              s_ravalid,
  output logic [ADDR_W-1:0] s_raaddr,
  input  logic              s_raready,
  input  logic              s_rvalid,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              s_rready,
  output logic              s_wavalid,
  output logic [ADDR_W-1:0] s_waaddr,
  input  logic              s_waready,
  output logic              s_wvalid,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_wready,
  input  logic              s_bvalid,
  input  logic [1:0]        s_bresp,
  output logic              s_bready,
  output logic              wr_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [1:0] {R_IDLE, R_M0, R_M1} rd_st_t;
  typedef enum logic [1:0] {W_IDLE, W_M0, W_M1} wr_st_t;

  rd_st_t rd_st;
  wr_st_t wr_st;
  logic rd_last, wr_last;
  logic [CNT_W-1:0] ar_cnt, r_cnt;
  logic [CNT_W-1:0] aw_cnt, w_cnt, b_cnt;
  logic rg0, rg1, wg0, wg1;
  logic ar_open, aw_open, w_open;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

  assign rg0 = (rd_st == R_M0);
  assign rg1 = (rd_st == R_M1);
  assign wg0 = (wr_st == W_M0);
  assign wg1 = (wr_st == W_M1);

  // address/data issue stops once a full line has been handed downstream
  assign ar_open = (ar_cnt != CNT_MAX);
  assign aw_open = (aw_cnt != CNT_MAX);
  assign w_open  = (w_cnt != CNT_MAX);

  assign s_ravalid = ar_open &
    (rg0 & m0_ravalid | rg1 & m1_ravalid);
  assign s_raaddr = rg0 ? m0_raaddr :
    rg1 ? m1_raaddr : '0;
  assign s_rready = rg0 & m0_rready |
    rg1 & m1_rready;

  assign m0_raready = rg0 & ar_open & s_raready;
  assign m1_raready = rg1 & ar_open & s_raready;
  assign m0_rvalid  = rg0 & s_rvalid;
  assign m1_rvalid  = rg1 & s_rvalid;
  assign m0_rdata   = rg0 ? s_rdata : '0;
  assign m1_rdata   = rg1 ? s_rdata : '0;

  assign s_wavalid = aw_open &
    (wg0 & m0_wavalid | wg1 & m1_wavalid);
  assign s_waaddr = wg0 ? m0_waaddr :
    wg1 ? m1_waaddr : '0;
  assign s_wvalid = w_open &
    (wg0 & m0_wvalid | wg1 & m1_wvalid);
  assign s_wdata = wg0 ? m0_wdata :
    wg1 ? m1_wdata : '0;
  assign s_bready = wg0 & m0_bready |
    wg1 & m1_bready;

  assign m0_waready = wg0 & aw_open & s_waready;
  assign m1_waready = wg1 & aw_open & s_waready;
  assign m0_wready  = wg0 & w_open & s_wready;
  assign m1_wready  = wg1 & w_open & s_wready;
  assign m0_bvalid  = wg0 & s_bvalid;
  assign m1_bvalid  = wg1 & s_bvalid;
  assign m0_bresp   = wg0 ? s_bresp : 2'b00;
  assign m1_bresp   = wg1 ? s_bresp : 2'b00;

  assign ar_hs = s_ravalid & s_raready;
  assign r_hs  = s_rvalid & s_rready;
  assign aw_hs = s_wavalid & s_waready;
  assign w_hs  = s_wvalid & s_wready;
  assign b_hs  = s_bvalid & s_bready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_st   <= R_IDLE;
      rd_last <= 1'b1;
      ar_cnt  <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (rd_st)
        R_IDLE: begin
          // rd_last=1 means m1 was served last, so m0 wins a tie
          if (m0_ravalid & (~m1_ravalid | rd_last))
            rd_st <= R_M0;
          else if (m1_ravalid)
            rd_st <= R_M1;
        end
        default: begin
          if (ar_hs)
            ar_cnt <= ar_cnt + ONE;
          if (r_hs) begin
            if (r_cnt == CNT_END) begin
              rd_st   <= R_IDLE;
              rd_last <= rg1;
              ar_cnt  <= '0;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + ONE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_st   <= W_IDLE;
      wr_last <= 1'b1;
      aw_cnt  <= '0;
      w_cnt   <= '0;
      b_cnt   <= '0;
    end else begin
      unique case (wr_st)
        W_IDLE: begin
          if (m0_wavalid & (~m1_wavalid | wr_last))
            wr_st <= W_M0;
          else if (m1_wavalid)
            wr_st <= W_M1;
        end
        default: begin
          if (aw_hs)
            aw_cnt <= aw_cnt + ONE;
          if (w_hs)
            w_cnt <= w_cnt + ONE;
          if (b_hs) begin
            if (b_cnt == CNT_END) begin
              wr_st   <= W_IDLE;
              wr_last <= wg1;
              aw_cnt  <= '0;
              w_cnt   <= '0;
              b_cnt   <= '0;
            end else begin
              b_cnt <= b_cnt + ONE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      wr_err <= 1'b0;
    else
      wr_err <= b_hs & (s_bresp != 2'b00);
  end

endmodule

// File: tb/tb_ysyx_22050518_mem_arbiter.sv
// Bench for the icache/dcache memory arbiter.
// Randomised bus-bridge model plus line-level master drivers.
module tb_ysyx_22050518_mem_arbiter;
  localparam int BEATS = 4;

  logic clk, rst;
  logic m0_ravalid, m0_raready, m0_rvalid, m0_rready;
  logic [63:0] m0_raaddr, m0_waaddr;
  logic [31:0] m0_rdata, m0_wdata;
  logic m0_wavalid, m0_waready, m0_wvalid, m0_wready;
  logic m0_bvalid, m0_bready;
  logic [1:0] m0_bresp;
  logic m1_ravalid, m1_raready, m1_rvalid, m1_rready;
  logic [63:0] m1_raaddr, m1_waaddr;
  logic [31:0] m1_rdata, m1_wdata;
  logic m1_wavalid, m1_waready, m1_wvalid, m1_wready;
  logic m1_bvalid, m1_bready;
  logic [1:0] m1_bresp;
  logic s_ravalid, s_raready, s_rvalid, s_rready;
  logic [63:0] s_raaddr, s_waaddr;
  logic [31:0] s_rdata, s_wdata;
  logic s_wavalid, s_waready, s_wvalid, s_wready;
  logic s_bvalid, s_bready;
  logic [1:0] s_bresp;
  logic wr_err;

  ysyx_22050518_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_ravalid(m0_ravalid), .m0_raaddr(m0_raaddr),
    .m0_raready(m0_raready), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_rready(m0_rready),
    .m0_wavalid(m0_wavalid), .m0_waaddr(m0_waaddr),
    .m0_waready(m0_waready), .m0_wvalid(m0_wvalid),
    .m0_wdata(m0_wdata), .m0_wready(m0_wready),
    .m0_bvalid(m0_bvalid), .m0_bresp(m0_bresp),
    .m0_bready(m0_bready),
    .m1_ravalid(m1_ravalid), .m1_raaddr(m1_raaddr),
    .m1_raready(m1_raready), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_rready(m1_rready),
    .m1_wavalid(m1_wavalid), .m1_waaddr(m1_waaddr),
    .m1_waready(m1_waready), .m1_wvalid(m1_wvalid),
    .m1_wdata(m1_wdata), .m1_wready(m1_wready),
    .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp),
    .m1_bready(m1_bready),
    .s_ravalid(s_ravalid), .s_raaddr(s_raaddr),
    .s_raready(s_raready), .s_rvalid(s_rvalid),
    .s_rdata(s_rdata), .s_rready(s_rready),
    .s_wavalid(s_wavalid), .s_waaddr(s_waaddr),
    .s_waready(s_waready), .s_wvalid(s_wvalid),
    .s_wdata(s_wdata), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp),
    .s_bready(s_bready), .wr_err(wr_err)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pulses = 0;
  int err_beat = 4;
  bit started = 0;
  logic err_exp = 1'b0;
  logic [31:0] salt;

  logic [63:0] rq[$];
  logic [63:0] awq[$];
  logic [31:0] wq[$];
  logic [31:0] mem_w [logic [63:0]];
  int pend_b = 0;
  int b_idx = 0;

  task automatic chk(input string tag, input logic [127:0] o,
                     input logic [127:0] e);
    total++;
    if (o !== e) begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [31:0] rd_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ salt;
  endfunction

  initial begin
    logic ar, r, aw, w, b, rs;
    logic [63:0] ara, awa;
    logic [31:0] wd;
    s_raready = 0; s_rvalid = 0; s_rdata = 0;
    s_waready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
    forever begin
      @(negedge clk);
      ar = s_ravalid & s_raready;
      r  = s_rvalid & s_rready;
      aw = s_wavalid & s_waready;
      w  = s_wvalid & s_wready;
      b  = s_bvalid & s_bready;
      ara = s_raaddr; awa = s_waaddr; wd = s_wdata;
      rs = rst;
      @(posedge clk);
      #1;
      if (rs) begin
        rq.delete(); awq.delete(); wq.delete();
        pend_b = 0; b_idx = 0;
        s_raready = 0; s_rvalid = 0; s_rdata = 0;
        s_waready = 0; s_wready = 0;
        s_bvalid = 0; s_bresp = 0;
      end else begin
        if (ar) rq.push_back(ara);
        if (r) begin
          void'(rq.pop_front());
          s_rvalid = 0;
        end
        if (aw) awq.push_back(awa);
        if (w) wq.push_back(wd);
        if (b) begin
          s_bvalid = 0;
          b_idx++;
        end
        while (awq.size() > 0 && wq.size() > 0) begin
          mem_w[awq.pop_front()] = wq.pop_front();
          pend_b++;
        end
        if (!s_rvalid && rq.size() > 0 && ($urandom % 3) != 0) begin
          s_rvalid = 1;
          s_rdata = rd_word(rq[0]);
        end
        if (!s_bvalid && pend_b > 0 && ($urandom % 3) != 0) begin
          s_bvalid = 1;
          pend_b--;
          s_bresp = ((b_idx % BEATS) == err_beat) ? 2'b10 : 2'b00;
        end
        s_raready = ($urandom % 4) != 0;
        s_waready = ($urandom % 4) != 0;
        s_wready  = ($urandom % 4) != 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("rd_excl",
        (m0_raready | m0_rvalid) & (m1_raready | m1_rvalid), 1'b0);
      chk("wr_excl", (m0_waready | m0_wready | m0_bvalid) &
        (m1_waready | m1_wready | m1_bvalid), 1'b0);
      chk("wr_err", wr_err, err_exp);
    end
    if (wr_err === 1'b1) pulses++;
    err_exp = !rst && s_bvalid && s_bready && (s_bresp != 2'b00);
  end

  task automatic set_r(input int idx, input logic v,
                       input logic [63:0] a, input logic rr);
    if (idx == 0) begin
      m0_ravalid = v; m0_raaddr = a; m0_rready = rr;
    end else begin
      m1_ravalid = v; m1_raaddr = a; m1_rready = rr;
    end
  endtask

  task automatic set_w(input int idx, input logic av, input logic [63:0] a,
                       input logic wv, input logic [31:0] d, input logic br);
    if (idx == 0) begin
      m0_wavalid = av; m0_waaddr = a; m0_wvalid = wv;
      m0_wdata = d; m0_bready = br;
    end else begin
      m1_wavalid = av; m1_waaddr = a; m1_wvalid = wv;
      m1_wdata = d; m1_bready = br;
    end
  endtask

  task automatic rd_line(input int idx, input logic [63:0] base,
                         input int stop_r, output logic [127:0] data,
                         output int first_a, output int last_r,
                         output int lat);
    int na, nr, t, start;
    logic rar, rv, rr;
    logic [31:0] rd;
    na = 0; nr = 0; t = 0; first_a = -1; last_r = -1;
    data = '0; rr = 1'b1; start = cyc;
    set_r(idx, 1'b1, base, rr);
    while (nr < stop_r && t < 400) begin
      @(negedge clk);
      t++;
      rar = (idx == 0) ? m0_raready : m1_raready;
      rv  = (idx == 0) ? m0_rvalid : m1_rvalid;
      rd  = (idx == 0) ? m0_rdata : m1_rdata;
      if (na >= BEATS) chk("rd_cap", rar, 1'b0);
      if (rar && na < BEATS) begin
        if (na == 0) first_a = cyc;
        na++;
      end
      if (rv && rr) begin
        data[nr*32 +: 32] = rd;
        nr++;
        last_r = cyc;
      end
      @(posedge clk);
      #1;
      rr = ($urandom % 4) != 0;
      set_r(idx, nr < stop_r, base + 64'(4 * na), rr);
    end
    set_r(idx, 1'b0, 64'h0, 1'b0);
    lat = first_a - start;
    chk("rd_timeout", nr, stop_r);
  endtask

  task automatic wr_line(input int idx, input logic [63:0] base,
                         output logic [127:0] wdat, output logic [7:0] brs,
                         output int first_aw, output int last_b);
    int naw, nw, nb, t;
    logic awr, wr, bv, br;
    logic [1:0] rsp;
    naw = 0; nw = 0; nb = 0; t = 0; first_aw = -1; last_b = -1;
    brs = '0; br = 1'b1;
    for (int i = 0; i < BEATS; i++) wdat[i*32 +: 32] = $urandom;
    set_w(idx, 1'b1, base, 1'b1, wdat[31:0], br);
    while (nb < BEATS && t < 400) begin
      @(negedge clk);
      t++;
      awr = (idx == 0) ? m0_waready : m1_waready;
      wr  = (idx == 0) ? m0_wready : m1_wready;
      bv  = (idx == 0) ? m0_bvalid : m1_bvalid;
      rsp = (idx == 0) ? m0_bresp : m1_bresp;
      if (naw >= BEATS) chk("wr_aw_cap", awr, 1'b0);
      if (nw >= BEATS) chk("wr_w_cap", wr, 1'b0);
      if (awr && naw < BEATS) begin
        if (naw == 0) first_aw = cyc;
        naw++;
      end
      if (wr && nw < BEATS) nw++;
      if (bv && br) begin
        brs[nb*2 +: 2] = rsp;
        nb++;
        last_b = cyc;
      end
      @(posedge clk);
      #1;
      br = ($urandom % 4) != 0;
      set_w(idx, nb < BEATS, base + 64'(4 * naw), nb < BEATS,
            (nw < BEATS) ? wdat[nw*32 +: 32] : 32'hDEAD_0005, br);
    end
    set_w(idx, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    chk("wr_timeout", nb, BEATS);
  endtask

  task automatic chk_rd(input logic [63:0] base, input logic [127:0] d);
    for (int i = 0; i < BEATS; i++)
      chk("rd_data", d[i*32 +: 32], rd_word(base + 64'(4 * i)));
  endtask

  task automatic chk_wr(input logic [63:0] base, input logic [127:0] d);
    for (int i = 0; i < BEATS; i++)
      chk("wr_data", mem_w[base + 64'(4 * i)], d[i*32 +: 32]);
  endtask

  task automatic zero_chk();
    chk("zero_ctl", {s_ravalid, s_rready, s_wavalid, s_wvalid, s_bready,
      m0_raready, m0_rvalid, m0_waready, m0_wready, m0_bvalid,
      m1_raready, m1_rvalid, m1_waready, m1_wready, m1_bvalid,
      wr_err}, 16'h0);
    chk("zero_addr", {s_raaddr, s_waaddr}, 128'h0);
    chk("zero_data", {s_wdata, m0_rdata, m1_rdata, m0_bresp, m1_bresp},
      100'h0);
  endtask

  task automatic hold_reqs(input logic v);
    m0_ravalid = v; m0_rready = v;
    m1_wavalid = v; m1_wvalid = v; m1_bready = v;
  endtask

  function automatic logic [63:0] rnd_base(input logic [31:0] top);
    return {32'h0, top | ($urandom & 32'h00FF_FFC0)};
  endfunction

  logic [127:0] d0, d1, wd;
  logic [7:0] brs;
  logic [63:0] a0, a1, aw;
  int f0, l0, f1, l1, lat0, lat1, fw, lw, p;

  initial begin
    salt = $urandom;
    set_r(0, 1'b0, 64'h0, 1'b0);
    set_r(1, 1'b0, 64'h0, 1'b0);
    set_w(0, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    set_w(1, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    hold_reqs(1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    zero_chk();
    started = 1;
    @(posedge clk);
    #1;
    hold_reqs(1'b0);
    rst = 1'b0;

    a0 = rnd_base(32'h8000_0000);
    a1 = rnd_base(32'h8100_0000);
    fork
      rd_line(0, a0, BEATS, d0, f0, l0, lat0);
      rd_line(1, a1, BEATS, d1, f1, l1, lat1);
    join
    chk("rr1_order", l0 < f1, 1'b1);
    chk("rr1_gap", (f1 - l0) >= 2, 1'b1);
    chk_rd(a0, d0);
    chk_rd(a1, d1);

    a0 = rnd_base(32'h8200_0000);
    a1 = rnd_base(32'h8300_0000);
    fork
      rd_line(0, a0, BEATS, d0, f0, l0, lat0);
      rd_line(1, a1, BEATS, d1, f1, l1, lat1);
    join
    chk("rr2_order", l0 < f1, 1'b1);
    chk_rd(a0, d0);
    chk_rd(a1, d1);

    a0 = 64'h8000_0000;
    rd_line(0, a0, BEATS, d0, f0, l0, lat0);
    chk("grant_lat", lat0 >= 1, 1'b1);
    chk_rd(a0, d0);
    a1 = rnd_base(32'h8400_0000);
    m0_ravalid = 1'b1;
    m0_raaddr = a1;
    @(negedge clk);
    chk("idle_gap", {s_ravalid, m0_raready, s_rready}, 3'b000);
    rd_line(0, a1, BEATS, d0, f0, l0, lat0);
    chk_rd(a1, d0);

    a0 = rnd_base(32'h8500_0000);
    a1 = rnd_base(32'h8600_0000);
    fork
      rd_line(0, a0, BEATS, d0, f0, l0, lat0);
      rd_line(1, a1, BEATS, d1, f1, l1, lat1);
    join
    chk("rr3_order", l1 < f0, 1'b1);
    chk_rd(a0, d0);
    chk_rd(a1, d1);

    a0 = rnd_base(32'h8700_0000);
    aw = rnd_base(32'h8800_0000);
    fork
      rd_line(0, a0, BEATS, d0, f0, l0, lat0);
      wr_line(1, aw, wd, brs, fw, lw);
    join
    chk("rw_overlap", (fw < l0) && (f0 < lw), 1'b1);
    chk("rw_bresp", brs, 8'h00);
    chk_rd(a0, d0);
    chk_wr(aw, wd);

    err_beat = 1;
    p = pulses;
    aw = rnd_base(32'h8900_0000);
    wr_line(0, aw, wd, brs, fw, lw);
    repeat (2) @(negedge clk);
    chk("err_pulse", pulses - p, 1);
    chk("err_bresp", brs, 8'b0000_1000);
    chk_wr(aw, wd);
    err_beat = 4;

    a0 = rnd_base(32'h8A00_0000);
    rd_line(0, a0, 2, d0, f0, l0, lat0);
    chk("abort_data", d0[63:0], {rd_word(a0 + 64'd4), rd_word(a0)});
    hold_reqs(1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    zero_chk();
    @(posedge clk);
    #1;
    hold_reqs(1'b0);
    rst = 1'b0;
    a1 = rnd_base(32'h8B00_0000);
    rd_line(1, a1, BEATS, d1, f1, l1, lat1);
    chk("post_rst_lat", lat1 >= 1, 1'b1);
    chk_rd(a1, d1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
